// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and legal parameter ranges.
package uart_pkg;

  // Transmitter FSM states; IDLE is zero so a cleared register reads as idle.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_e;

  // Legal frame-format ranges.
  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 8;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  // Wide enough to count up to DATA_BITS_MAX data bits.
  localparam int BIT_CNT_W = $clog2(DATA_BITS_MAX + 1);

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: accepts one word per frame and shifts it out LSB first,
// paced by an external one-clk baud_tick strobe.
//
// Handshake: a word is accepted on a rising clk edge where tx_valid and
// tx_ready are both 1. tx_ready is registered, high only in IDLE, and never
// looks at tx_valid; tx_data is captured at accept and ignored afterwards.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done,
  output logic [2:0]           state_dbg
);

  // Reject illegal frame formats while elaborating.
  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be between 5 and 8");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS);
  localparam logic                 LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic                 ODD_FLIP  = 1'(PARITY_ODD);

  tx_state_e              state;
  logic [DATA_BITS-1:0]   shift_reg;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic                   stop_cnt;
  logic                   parity_bit;

  assign state_dbg = state;

  // Frame sequencer; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      txd        <= 1'b1;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      parity_bit <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        // A tick on the accept edge is ignored; the start bit waits for
        // the next tick so it lasts a full bit period.
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shift_reg  <= tx_data;
            parity_bit <= (^tx_data) ^ ODD_FLIP;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (baud_tick) begin
            txd   <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            txd       <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= BIT_CNT_W'(1);
            state     <= DATA;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_cnt == LAST_DATA) begin
              if (PARITY_EN != 0) begin
                txd   <= parity_bit;
                state <= PARITY;
              end else begin
                txd   <= 1'b1;
                state <= STOP;
              end
            end else begin
              txd       <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
            end
          end
        end
        PARITY: begin
          if (baud_tick) begin
            txd   <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (baud_tick) begin
            if (stop_cnt == LAST_STOP) begin
              tx_done  <= 1'b1;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          txd      <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
- REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning the number of data bits per frame; legal values are 5 to 8.
- REQ-002 The block SHALL have parameter PARITY_EN, default 0, meaning a parity bit is inserted when set to 1.
- REQ-003 The block SHALL have parameter PARITY_ODD, default 0, meaning odd parity when 1 and even parity when 0; it is ignored when PARITY_EN is 0.
- REQ-004 The block SHALL have parameter STOP_BITS, default 1, meaning the number of stop bits; legal values are 1 and 2.
- REQ-005 clk  input  1  the single clock; all logic is on its rising edge.
- REQ-006 rst  input  1  reset, synchronous and active-high.
- REQ-007 baud_tick  input  1  one-clk strobe once per bit period, driven by baud_gen.
- REQ-008 tx_data  input  DATA_BITS  the byte to send; sampled only on accept.
- REQ-009 tx_valid  input  1  upstream has data on tx_data.
- REQ-010 tx_ready  output  1  the block can accept data this cycle.
- REQ-011 txd  output  1  serial line; idle high.
- REQ-012 busy  output  1  a frame is pending or in flight.
- REQ-013 tx_done  output  1  one-clk pulse when the last stop bit completes.

Function
- REQ-014 An accept SHALL occur on a clk edge where tx_valid=1 and tx_ready=1.
- REQ-015 tx_ready SHALL be 1 only in state IDLE; tx_ready SHALL be a registered function of state and SHALL NOT depend combinationally on tx_valid.
- REQ-016 The FSM states SHALL be IDLE, WAIT, START, DATA, PARITY and STOP.
- REQ-017 On accept, the block SHALL latch tx_data into a shift register, compute the parity bit, and move from IDLE to WAIT.
- REQ-018 In WAIT, on the next baud_tick, the block SHALL drive txd=0 and move to START, so that every bit lasts exactly one tick period.
- REQ-019 In START, on baud_tick, the block SHALL move to DATA and drive bit 0 (LSB first).
- REQ-020 In DATA, each baud_tick SHALL shift to the next bit.
- REQ-021 A bit counter SHALL count the data bits; after DATA_BITS bits, the next baud_tick SHALL move to PARITY if PARITY_EN=1, otherwise to STOP.
- REQ-022 The parity bit SHALL be the XOR of all data bits, inverted when PARITY_ODD=1.
- REQ-023 In PARITY, txd SHALL carry the parity bit, and on baud_tick the block SHALL move to STOP.
- REQ-024 In STOP, txd SHALL be 1 for STOP_BITS tick periods.
- REQ-025 On the baud_tick that ends the last stop bit, the block SHALL move to IDLE and pulse tx_done for exactly one clk.
- REQ-026 tx_ready SHALL be 1 on the cycle after the tx_done pulse, so back-to-back frames are possible with one WAIT period between them.
- REQ-027 txd SHALL be registered with no combinational path from any input.
- REQ-028 busy SHALL be 1 in every state other than IDLE.
- REQ-029 A baud_tick coincident with an accept in IDLE SHALL be ignored; the start bit SHALL begin on the following tick.
- REQ-030 tx_valid asserted while the block is not in IDLE SHALL have no effect, and tx_data changes after accept SHALL NOT alter the frame.
- REQ-031 If baud_tick stays 0, the FSM SHALL hold its state and txd indefinitely.
- REQ-032 Non-legal values of DATA_BITS or STOP_BITS SHALL cause an elaboration-time error.

Reset
- REQ-033 rst SHALL be sampled only on the rising edge of clk and SHALL take priority over all other inputs.
- REQ-034 After reset: state=IDLE, txd=1, tx_ready=1, busy=0, tx_done=0, and the bit counter and shift register are 0.
- REQ-035 Reset asserted mid-frame SHALL abort the frame; txd SHALL be 1 from the next edge, and no tx_done pulse SHALL occur.

Structure
- REQ-036 The state enum SHALL live in the shared package uart_pkg.
- REQ-037 The DATA_BITS and STOP_BITS legal-range constants SHALL live in uart_pkg.
- REQ-038 uart_tx SHALL have no sub-module; baud_gen SHALL be instantiated beside it at the top level, feeding baud_tick.

Verification (bench drives baud_tick every 4 clk)
- REQ-039 Reset: rst high for 3 clk -> txd=1, tx_ready=1, busy=0, tx_done=0.
- REQ-040 8N1 frame, tx_data=0x55 -> txd sequence 0,1,0,1,0,1,0,1,0,1, each bit exactly 4 clk; tx_done pulses once; frame is 40 clk from the first tick after accept.
- REQ-041 PARITY_EN=1, tx_data=0xA5 -> parity bit 0 when PARITY_ODD=0 and 1 when PARITY_ODD=1; STOP_BITS=2 gives a stop high for 8 clk.
- REQ-042 Back-to-back frames, tx_valid held high with 0x01 then 0x80 -> second accept on the cycle after tx_done; both frames are decoded correctly by the bench.
- REQ-043 Accept coincident with baud_tick -> start bit begins on the next tick, not the current one.
- REQ-044 rst pulsed during data bit 3 of 0xFF -> txd=1 on the next edge, no tx_done, and a new frame 0x3C afterwards is correct.
